ascii_to_int_parser: RTL and testbench
======================================

ASCII_TO_INT_PARSER -- requirements
Module: ascii_to_int_parser

Interface
REQ-001 SHALL have parameter MAX_MAG, default 100: largest accepted magnitude.
REQ-002 SHALL have parameter MAX_DIGITS, default 3: max decimal digits per field.
REQ-003 SHALL have port clock  input  1: sole clock; all state changes on rising edge.
REQ-004 SHALL have port reset_n  input  1: synchronous, active-low reset.
REQ-005 SHALL have port rx_data  input  8: ASCII byte from the receive path.
REQ-006 SHALL have port rx_valid  input  1: rx_data valid this cycle.
REQ-007 SHALL have port rx_ready  output  1: parser can accept a byte; a byte is consumed when rx_valid && rx_ready at the clock edge.
REQ-008 SHALL have port value  output  32: signed two's-complement result; holds last emitted value.
REQ-009 SHALL have port value_valid  output  1: one-cycle pulse, value updated.
REQ-010 SHALL have port err  output  1: one-cycle pulse, malformed or rejected field.
REQ-011 SHALL have port busy  output  1: high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, DIGIT, EMIT and DISCARD, with all outputs registered.
REQ-013 Character classes SHALL be: digit 0x30-0x39; sign '-' 0x2D or '+' 0x2B; terminator CR 0x0D, LF 0x0A or ',' 0x2C; space 0x20; everything else is illegal.
REQ-014 IDLE SHALL act on the consumed byte as follows.
- '-': set neg=1, go to DIGIT with count=0.
- '+': set neg=0, go to DIGIT with count=0.
- digit: acc=d, count=1, go to DIGIT.
- space or terminator: ignore, stay in IDLE.
- illegal: pulse err, go to DISCARD.
REQ-015 DIGIT SHALL act on the consumed byte as follows.
- digit with count<MAX_DIGITS: acc=acc*10+d, count+1.
- digit with count==MAX_DIGITS: pulse err, go to DISCARD.
- terminator with count>=1: go to EMIT.
- terminator with count==0: pulse err, go to IDLE.
- space, sign or illegal: pulse err, go to DISCARD.
REQ-016 acc SHALL be at least 10 bits unsigned, sized to hold 10^MAX_DIGITS-1 without overflow.
REQ-017 EMIT SHALL last exactly one cycle with rx_ready=0, then return to IDLE; neg, acc and count SHALL clear on leaving EMIT.
REQ-018 In EMIT with acc<=MAX_MAG, value SHALL become neg ? -acc : acc and value_valid SHALL pulse for that one cycle; "-0" SHALL yield value=0.
REQ-019 value_valid SHALL assert on the edge following acceptance of the terminator (latency 1 cycle from terminator accept).
REQ-020 DISCARD SHALL consume and drop all bytes until a terminator, then go to IDLE with no pulse.
REQ-021 rx_ready SHALL be 1 in IDLE, DIGIT and DISCARD, and 0 in EMIT and during reset.
REQ-022 value_valid and err SHALL never assert in the same cycle.
REQ-023 No byte SHALL be consumed when rx_valid=0; state SHALL hold indefinitely.

Reset
REQ-024 While reset_n=0 at an edge: state=IDLE, value=0, value_valid=0, err=0, busy=0, rx_ready=0, and acc, count and neg cleared.
REQ-025 Reset mid-field SHALL abandon the partial field without a pulse; the byte presented during reset SHALL NOT be consumed.

Configuration
REQ-026 Macro ASCII_PARSE_CLAMP_EN SHALL select out-of-range handling.
REQ-027 With ASCII_PARSE_CLAMP_EN defined, EMIT with acc>MAX_MAG SHALL output value=neg ? -MAX_MAG : MAX_MAG with a value_valid pulse and no err.
REQ-028 Without it, EMIT with acc>MAX_MAG SHALL pulse err, leave value unchanged and not pulse value_valid.

Verification
REQ-029 Bytes "-","4","2",CR -> value_valid one cycle after CR accept, value=-42 (0xFFFFFFD6), err=0.
REQ-030 Bytes "1","0","0",",","+","7",LF -> value=100 then value=7, two separate value_valid pulses, rx_ready low one cycle after each terminator.
REQ-031 Bytes "1","5","0",CR -> with CLAMP_EN value=100 and value_valid pulse; without it err pulse and value unchanged.
REQ-032 Bytes "1","2","3","4","5",CR then "9",CR -> err on the 4th digit, "5" discarded, no pulse at first CR; then value=9.
REQ-033 Bytes "-",CR, then "x", then "3",CR -> err at the first CR, err at "x", DISCARD swallows "3", then IDLE; no value_valid.
REQ-034 Bytes "-","6", then reset_n=0 for 2 cycles, then "8",CR -> no pulses during reset, outputs at reset values, then value=8.

Source files
------------

// File: rtl/ascii_to_int_parser.sv
// ASCII decimal field parser: optional sign, up to MAX_DIGITS digits, terminator -> signed 32-bit value.
// Build option ASCII_PARSE_CLAMP_EN saturates out-of-range magnitudes to +/-MAX_MAG instead of flagging err.
module ascii_to_int_parser #(
    parameter int MAX_MAG    = 100,
    parameter int MAX_DIGITS = 3
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic [31:0] value,
    output logic        value_valid,
    output logic        err,
    output logic        busy,
    output logic [1:0]  o_dbg_state
);
    localparam int ACC_RAW = $clog2(10 ** MAX_DIGITS);
    localparam int ACC_W   = (ACC_RAW < 10) ? 10 : ACC_RAW;
    localparam int CNT_W   = $clog2(MAX_DIGITS + 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        DIGIT   = 2'd1,
        EMIT    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t             r_state;
    logic [ACC_W-1:0]   r_acc;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_neg;

    state_t             w_state_nx;
    logic [ACC_W-1:0]   w_acc_nx;
    logic [CNT_W-1:0]   w_cnt_nx;
    logic               w_neg_nx;
    logic [31:0]        w_value_nx;
    logic               w_vv_nx;
    logic               w_err_nx;

    logic               w_take;
    logic               w_is_digit;
    logic               w_is_sign;
    logic               w_is_term;
    logic               w_is_space;
    logic [ACC_W-1:0]   w_digit;
    logic [31:0]        w_acc_ext;
    logic               w_in_range;

    // Handshake: a byte is consumed only on a clock edge where rx_valid && rx_ready;
    // rx_ready is registered and drops for the single EMIT cycle and throughout reset.
    assign w_take      = rx_valid && rx_ready;
    assign w_is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_sign   = (rx_data == 8'h2D) || (rx_data == 8'h2B);
    assign w_is_term   = (rx_data == 8'h0D) || (rx_data == 8'h0A) || (rx_data == 8'h2C);
    assign w_is_space  = (rx_data == 8'h20);
    assign w_digit     = ACC_W'(rx_data[3:0]);
    assign w_acc_ext   = 32'(r_acc);
    assign w_in_range  = (w_acc_ext <= 32'(MAX_MAG));
    assign o_dbg_state = r_state;

    always_comb begin
        w_state_nx = r_state;
        w_acc_nx   = r_acc;
        w_cnt_nx   = r_cnt;
        w_neg_nx   = r_neg;
        w_value_nx = value;
        w_vv_nx    = 1'b0;
        w_err_nx   = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_take) begin
                    if (w_is_sign) begin
                        w_neg_nx   = (rx_data == 8'h2D);
                        w_acc_nx   = '0;
                        w_cnt_nx   = '0;
                        w_state_nx = DIGIT;
                    end else if (w_is_digit) begin
                        w_acc_nx   = w_digit;
                        w_cnt_nx   = CNT_W'(1);
                        w_state_nx = DIGIT;
                    end else if (!(w_is_space || w_is_term)) begin
                        w_err_nx   = 1'b1;
                        w_state_nx = DISCARD;
                    end
                end
            end

            DIGIT: begin
                if (w_take) begin
                    if (w_is_digit) begin
                        if (r_cnt < CNT_W'(MAX_DIGITS)) begin
                            w_acc_nx = (r_acc * ACC_W'(10)) + w_digit;
                            w_cnt_nx = r_cnt + CNT_W'(1);
                        end else begin
                            w_err_nx   = 1'b1;
                            w_state_nx = DISCARD;
                        end
                    end else if (w_is_term) begin
                        if (r_cnt != '0) begin
                            w_state_nx = EMIT;
                        end else begin
                            w_err_nx   = 1'b1;
                            w_state_nx = IDLE;
                        end
                    end else begin
                        w_err_nx   = 1'b1;
                        w_state_nx = DISCARD;
                    end
                end
            end

            EMIT: begin
                w_state_nx = IDLE;
                if (w_in_range) begin
                    w_value_nx = r_neg ? -w_acc_ext : w_acc_ext;
                    w_vv_nx    = 1'b1;
                end else begin
`ifdef ASCII_PARSE_CLAMP_EN
                    w_value_nx = r_neg ? -32'(MAX_MAG) : 32'(MAX_MAG);
                    w_vv_nx    = 1'b1;
`else
                    w_err_nx   = 1'b1;
`endif
                end
            end

            DISCARD: begin
                if (w_take && w_is_term) begin
                    w_state_nx = IDLE;
                end
            end

            default: begin
                w_state_nx = IDLE;
            end
        endcase

        // Field context never survives into IDLE or DISCARD.
        if ((w_state_nx == IDLE) || (w_state_nx == DISCARD)) begin
            w_acc_nx = '0;
            w_cnt_nx = '0;
            w_neg_nx = 1'b0;
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_neg       <= 1'b0;
            value       <= '0;
            value_valid <= 1'b0;
            err         <= 1'b0;
            busy        <= 1'b0;
            rx_ready    <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_acc       <= w_acc_nx;
            r_cnt       <= w_cnt_nx;
            r_neg       <= w_neg_nx;
            value       <= w_value_nx;
            value_valid <= w_vv_nx;
            err         <= w_err_nx;
            busy        <= (w_state_nx != IDLE);
            rx_ready    <= (w_state_nx != EMIT);
        end
    end

endmodule

// File: tb/tb_ascii_to_int_parser.sv
// Directed bench for ascii_to_int_parser: byte sequences with hand-computed results.
// Honours ASCII_PARSE_CLAMP_EN when choosing out-of-range expectations.
module tb_ascii_to_int_parser;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CM = 8'h2C;

    logic        clock;
    logic        reset_n;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [31:0] value;
    logic        value_valid;
    logic        err;
    logic        busy;
    logic [1:0]  o_dbg_state;

    int checks = 0;
    int errors = 0;
    int vv_seen = 0;
    int err_seen = 0;
    int both_seen = 0;
    int exp_vv = 0;
    int exp_err = 0;

    logic s_err, s_vv, s_ready, s_busy;

    ascii_to_int_parser dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .value       (value),
        .value_valid (value_valid),
        .err         (err),
        .busy        (busy),
        .o_dbg_state (o_dbg_state)
    );

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // pulse monitor, sampled away from the active edge
    always @(negedge clock) begin
        if (value_valid === 1'b1) vv_seen++;
        if (err === 1'b1) err_seen++;
        if (value_valid === 1'b1 && err === 1'b1) both_seen++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // driver: present one byte once rx_ready is seen, then sample outputs after the edge
    task automatic send(input logic [7:0] b);
        int t;
        t = 0;
        @(negedge clock);
        while (rx_ready !== 1'b1 && t < 20) begin
            @(negedge clock);
            t++;
        end
        check("ready_before_byte", {31'd0, rx_ready}, 32'd1);
        rx_data  = b;
        rx_valid = 1'b1;
        @(posedge clock);
        #1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        s_err    = err;
        s_vv     = value_valid;
        s_ready  = rx_ready;
        s_busy   = busy;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send(s[i]);
    endtask

    // call right after the terminator byte
    task automatic expect_emit(input string tag, input logic [31:0] v);
        check({tag, "_ready_low_in_emit"}, {31'd0, s_ready}, 32'd0);
        check({tag, "_no_early_valid"}, {31'd0, s_vv}, 32'd0);
        step();
        check({tag, "_valid"}, {31'd0, value_valid}, 32'd1);
        check({tag, "_value"}, value, v);
        check({tag, "_no_err"}, {31'd0, err}, 32'd0);
        check({tag, "_ready_back"}, {31'd0, rx_ready}, 32'd1);
        exp_vv++;
        step();
        check({tag, "_valid_one_cycle"}, {31'd0, value_valid}, 32'd0);
    endtask

    task automatic expect_emit_err(input string tag, input logic [31:0] held);
        check({tag, "_ready_low_in_emit"}, {31'd0, s_ready}, 32'd0);
        step();
        check({tag, "_err"}, {31'd0, err}, 32'd1);
        check({tag, "_no_valid"}, {31'd0, value_valid}, 32'd0);
        check({tag, "_value_held"}, value, held);
        exp_err++;
        step();
    endtask

    initial begin
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = "5";
        s_err = 0; s_vv = 0; s_ready = 0; s_busy = 0;

        // reset state, with a byte presented that must not be taken
        idle(3);
        check("rst_value", value, 32'd0);
        check("rst_valid", {31'd0, value_valid}, 32'd0);
        check("rst_err", {31'd0, err}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, rx_ready}, 32'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        step();
        check("post_rst_ready", {31'd0, rx_ready}, 32'd1);
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        // "-42" CR
        send("-");
        check("neg_busy", {31'd0, s_busy}, 32'd1);
        send_str("42");
        send(CR);
        expect_emit("m42", 32'hFFFF_FFD6);

        // "100," then "+7" LF
        send_str("100");
        send(CM);
        expect_emit("p100", 32'd100);
        send_str("+7");
        send(LF);
        expect_emit("p7", 32'd7);

        // out of range "150"
        send_str("150");
        send(CR);
`ifdef ASCII_PARSE_CLAMP_EN
        expect_emit("r150", 32'd100);
`else
        expect_emit_err("r150", 32'd7);
`endif

        // too many digits, then "9"
        send_str("123");
        send("4");
        check("toolong_err", {31'd0, s_err}, 32'd1);
        check("toolong_busy", {31'd0, s_busy}, 32'd1);
        exp_err++;
        send("5");
        check("discard_5_no_err", {31'd0, s_err}, 32'd0);
        send(CR);
        check("discard_cr_no_err", {31'd0, s_err}, 32'd0);
        check("discard_cr_no_valid", {31'd0, s_vv}, 32'd0);
        check("discard_cr_ready", {31'd0, s_ready}, 32'd1);
        check("discard_cr_idle", {31'd0, s_busy}, 32'd0);
        step();
        check("discard_no_pulse", {31'd0, value_valid}, 32'd0);
        send("9");
        send(CR);
        expect_emit("p9", 32'd9);

        // bare sign, illegal byte, swallowed digit
        send("-");
        send(CR);
        check("bare_sign_err", {31'd0, s_err}, 32'd1);
        check("bare_sign_idle", {31'd0, s_busy}, 32'd0);
        exp_err++;
        send("x");
        check("illegal_err", {31'd0, s_err}, 32'd1);
        check("illegal_busy", {31'd0, s_busy}, 32'd1);
        exp_err++;
        send("3");
        check("swallow_3", {31'd0, s_err}, 32'd0);
        send(CR);
        check("swallow_cr_idle", {31'd0, s_busy}, 32'd0);
        check("swallow_cr_no_valid", {31'd0, s_vv}, 32'd0);
        step();
        check("swallow_no_pulse", {31'd0, value_valid}, 32'd0);
        check("swallow_value_held", value, 32'd9);

        // boundaries and odd forms
        send_str("-0");
        send(CR);
        expect_emit("m0", 32'd0);
        send_str("-100");
        send(LF);
        expect_emit("m100", 32'hFFFF_FF9C);
        send_str("101");
        send(CR);
`ifdef ASCII_PARSE_CLAMP_EN
        expect_emit("r101", 32'd100);
`else
        expect_emit_err("r101", 32'hFFFF_FF9C);
`endif
        send_str(" 5");
        send(CR);
        expect_emit("sp5", 32'd5);
        send("1");
        idle(5);
        check("hold_busy", {31'd0, busy}, 32'd1);
        check("hold_ready", {31'd0, rx_ready}, 32'd1);
        send("2");
        send(CR);
        expect_emit("p12", 32'd12);
        send("-");
        send("+");
        check("sign_in_digit_err", {31'd0, s_err}, 32'd1);
        exp_err++;
        send(CM);

        // reset mid-field, byte presented during reset must be dropped
        send_str("-6");
        @(negedge clock);
        reset_n  = 1'b0;
        rx_valid = 1'b1;
        rx_data  = "7";
        step();
        check("midrst_value", value, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_ready", {31'd0, rx_ready}, 32'd0);
        step();
        check("midrst_valid", {31'd0, value_valid}, 32'd0);
        check("midrst_err", {31'd0, err}, 32'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        rx_valid = 1'b0;
        send("8");
        send(CR);
        expect_emit("p8", 32'd8);

        idle(3);
        check("total_valid_pulses", 32'(vv_seen), 32'(exp_vv));
        check("total_err_pulses", 32'(err_seen), 32'(exp_err));
        check("valid_err_overlap", 32'(both_seen), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // hard stop guard
    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
